axi_fabric_csr_v2: RTL and testbench

//   Second-generation AXI4-Lite control/status slave for the ternary fabric. Decodes host writes into

---
 rtl/axi_fabric_csr_v2.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_axi_fabric_csr_v2.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fabric_csr_v2.sv
// rtl/axi_fabric_csr_v2.sv - AXI4-Lite control/status slave for the ternary fabric
// Purpose: decodes host AXI4-Lite writes into fabric configuration registers and
//   weight/input SRAM write strobes, and serves reads of results, zero-skip
//   counters and profiling counters. Keeps a sticky done flag and locks the
//   configuration and SRAM windows while a run is in progress.
// Ports:
//   s_axi_aclk, s_axi_aresetn      clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*         AXI4-Lite slave channels
//   fabric_base_addr..lane_mask    configuration outputs
//   fabric_start / fabric_done     run request level / completion input
//   vector_results, skip_counts    per-lane 32-bit values, lane i at [i*32+:32]
//   cycle_count, utilization_count profiling counters
//   sram_waddr/sram_wdata          SRAM write address/data
//   sram_we_weight/sram_we_input   one-cycle SRAM write strobes
//   irq                            (TFAB_IRQ_EN only) done_sticky & IRQ_ENABLE, registered
// Build option: define TFAB_IRQ_EN to add irq and the IRQ_ENABLE register at 0x028.
module axi_fabric_csr_v2 #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LANES  = 15,
  parameter int SRAM_AW    = 10,
  parameter int SRAM_DW    = 24
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     fabric_base_addr,
  output logic [15:0]               fabric_depth,
  output logic [7:0]                fabric_stride,
  output logic [31:0]               fabric_exec_hints,
  output logic [15:0]               fabric_lane_count,
  output logic [NUM_LANES-1:0]      fabric_lane_mask,
  output logic                      fabric_start,
  input  logic                      fabric_done,
  input  logic [NUM_LANES*32-1:0]   vector_results,
  input  logic [NUM_LANES*32-1:0]   skip_counts,
  input  logic [31:0]               cycle_count,
  input  logic [31:0]               utilization_count,
`ifdef TFAB_IRQ_EN
  output logic                      irq,
`endif
  output logic [SRAM_AW-1:0]        sram_waddr,
  output logic [SRAM_DW-1:0]        sram_wdata,
  output logic                      sram_we_weight,
  output logic                      sram_we_input
);

  localparam logic [16:0] SRAM_SPAN = 17'(4 << SRAM_AW);
  localparam logic [31:0] ID_VALUE  = {8'h02, 8'(NUM_LANES), 16'h7E81};

  typedef enum logic [1:0] {W_IDLE, W_GOTA, W_GOTD, W_RESP} wstate_t;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) v[b*8 +: 8] = new_v[b*8 +: 8];
    return v;
  endfunction

  wstate_t                r_wstate, w_wstate_nxt;
  logic [15:0]            r_awaddr;
  logic [31:0]            r_wdata;
  logic [3:0]             r_wstrb;
  logic [1:0]             r_bresp;
  logic                   r_rvalid;
  logic [31:0]            r_rdata;
  logic [1:0]             r_rresp;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [15:0]            r_depth;
  logic [7:0]             r_stride;
  logic [31:0]            r_hints;
  logic [15:0]            r_lcount;
  logic [NUM_LANES-1:0]   r_mask;
  logic                   r_start;
  logic                   r_sticky;
  logic [SRAM_AW-1:0]     r_sram_waddr;
  logic [SRAM_DW-1:0]     r_sram_wdata;
  logic                   r_we_w;
  logic                   r_we_i;
`ifdef TFAB_IRQ_EN
  logic                   r_irq_en;
  logic                   r_irq;
`endif

  logic                   w_commit;
  logic [15:0]            w_waddr16;
  logic [15:0]            w_wword;
  logic [31:0]            w_wdata_sel;
  logic [3:0]             w_wstrb_sel;
  logic                   w_is_cfg;
  logic                   w_in_wwin;
  logic                   w_in_iwin;
  logic                   w_werr;
  logic                   w_ok;
  logic [31:0]            w_cfg_old;
  logic [31:0]            w_merged;
  logic [15:0]            w_lc_clamped;
  logic                   w_start_set;
  logic                   w_sticky_clr;
  logic [15:0]            w_rword;
  logic [31:0]            w_rd_data;
  logic                   w_rd_err;
  logic                   w_unused;

  // ---------------- write FSM: state register ----------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_wstate <= W_IDLE;
    else                r_wstate <= w_wstate_nxt;
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) w_wstate_nxt = W_RESP;
        else if (s_axi_awvalid)            w_wstate_nxt = W_GOTA;
        else if (s_axi_wvalid)             w_wstate_nxt = W_GOTD;
      end
      W_GOTA:  if (s_axi_wvalid)  w_wstate_nxt = W_RESP;
      W_GOTD:  if (s_axi_awvalid) w_wstate_nxt = W_RESP;
      default: if (s_axi_bready)  w_wstate_nxt = W_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    s_axi_awready = (r_wstate == W_IDLE) || (r_wstate == W_GOTD);
    s_axi_wready  = (r_wstate == W_IDLE) || (r_wstate == W_GOTA);
    s_axi_bvalid  = (r_wstate == W_RESP);
  end

  assign s_axi_bresp = r_bresp;
  // The transaction commits on the edge where the second half (or both) is accepted.
  assign w_commit    = (r_wstate != W_RESP) && (w_wstate_nxt == W_RESP);

  // Whichever half arrived first was latched; the other comes straight off the bus.
  assign w_waddr16   = (r_wstate == W_GOTA) ? r_awaddr : s_axi_awaddr[15:0];
  assign w_wdata_sel = (r_wstate == W_GOTD) ? r_wdata  : s_axi_wdata;
  assign w_wstrb_sel = (r_wstate == W_GOTD) ? r_wstrb  : s_axi_wstrb;
  assign w_wword     = {w_waddr16[15:2], 2'b00};

  assign w_is_cfg  = (w_wword >= 16'h0008) && (w_wword <= 16'h001C);
  assign w_in_wwin = ({1'b0, w_wword} >= 17'h01000) && ({1'b0, w_wword} < 17'h01000 + SRAM_SPAN);
  assign w_in_iwin = ({1'b0, w_wword} >= 17'h02000) && ({1'b0, w_wword} < 17'h02000 + SRAM_SPAN);

  // Anything not explicitly writable (RO offsets, result/skip windows, holes) is SLVERR.
  always_comb begin
    w_werr = 1'b1;
    if (w_wword == 16'h0000 || w_wword == 16'h0004) w_werr = 1'b0;
    else if (w_is_cfg)                               w_werr = r_start;
    else if (w_in_wwin || w_in_iwin)                 w_werr = r_start || (w_wstrb_sel[2:0] != 3'b111);
`ifdef TFAB_IRQ_EN
    else if (w_wword == 16'h0028)                    w_werr = 1'b0;
`endif
  end

  assign w_ok         = w_commit && !w_werr;
  assign w_start_set  = w_ok && (w_wword == 16'h0000) && w_wstrb_sel[0] && w_wdata_sel[0];
  assign w_sticky_clr = w_ok && (w_wword == 16'h0004) && w_wstrb_sel[0] && w_wdata_sel[1];

  always_comb begin
    w_cfg_old = '0;
    case (w_wword[4:2])
      3'd2:    w_cfg_old = 32'(r_base);
      3'd3:    w_cfg_old = 32'(r_depth);
      3'd4:    w_cfg_old = 32'(r_stride);
      3'd5:    w_cfg_old = r_hints;
      3'd6:    w_cfg_old = 32'(r_lcount);
      3'd7:    w_cfg_old = 32'(r_mask);
      default: w_cfg_old = '0;
    endcase
  end

  assign w_merged = f_merge(w_cfg_old, w_wdata_sel, w_wstrb_sel);

  always_comb begin
    if (w_merged[15:0] == 16'd0)                  w_lc_clamped = 16'd1;
    else if (w_merged[15:0] > 16'(NUM_LANES))     w_lc_clamped = 16'(NUM_LANES);
    else                                          w_lc_clamped = w_merged[15:0];
  end

  // ---------------- write datapath and registers ----------------
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_bresp      <= 2'b00;
      r_base       <= '0;
      r_depth      <= '0;
      r_stride     <= '0;
      r_hints      <= '0;
      r_lcount     <= 16'(NUM_LANES);
      r_mask       <= '1;
      r_start      <= 1'b0;
      r_sticky     <= 1'b0;
      r_sram_waddr <= '0;
      r_sram_wdata <= '0;
      r_we_w       <= 1'b0;
      r_we_i       <= 1'b0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) r_awaddr <= s_axi_awaddr[15:0];
      if (s_axi_wvalid && s_axi_wready) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
      if (w_commit) r_bresp <= w_werr ? 2'b10 : 2'b00;

      if (w_ok && w_is_cfg) begin
        case (w_wword[4:2])
          3'd2:    r_base   <= ADDR_WIDTH'(w_merged);
          3'd3:    r_depth  <= w_merged[15:0];
          3'd4:    r_stride <= w_merged[7:0];
          3'd5:    r_hints  <= w_merged;
          3'd6:    r_lcount <= w_lc_clamped;
          default: r_mask   <= w_merged[NUM_LANES-1:0];
        endcase
      end

      // A start request overrides a coincident done: the new run stays requested.
      if (w_start_set) begin
        r_start  <= 1'b1;
        r_sticky <= 1'b0;
      end else begin
        if (fabric_done)             r_start  <= 1'b0;
        if (fabric_done && r_start)  r_sticky <= 1'b1;
        else if (w_sticky_clr)       r_sticky <= 1'b0;
      end

      r_we_w <= w_ok && w_in_wwin;
      r_we_i <= w_ok && w_in_iwin;
      if (w_ok && (w_in_wwin || w_in_iwin)) begin
        r_sram_waddr <= w_waddr16[SRAM_AW+1:2];
        r_sram_wdata <= w_wdata_sel[SRAM_DW-1:0];
      end
    end
  end

`ifdef TFAB_IRQ_EN
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ok && (w_wword == 16'h0028) && w_wstrb_sel[0]) r_irq_en <= w_wdata_sel[0];
      r_irq <= r_sticky && r_irq_en;
    end
  end
  assign irq = r_irq;
`endif

  // ---------------- read decode ----------------
  assign w_rword = {s_axi_araddr[15:2], 2'b00};

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    case (w_rword)
      16'h0000: w_rd_data = {31'd0, r_start};
      16'h0004: w_rd_data = {30'd0, r_sticky, r_start};
      16'h0008: w_rd_data = 32'(r_base);
      16'h000C: w_rd_data = 32'(r_depth);
      16'h0010: w_rd_data = 32'(r_stride);
      16'h0014: w_rd_data = r_hints;
      16'h0018: w_rd_data = 32'(r_lcount);
      16'h001C: w_rd_data = 32'(r_mask);
      16'h0020: w_rd_data = cycle_count;
      16'h0024: w_rd_data = utilization_count;
`ifdef TFAB_IRQ_EN
      16'h0028: w_rd_data = {31'd0, r_irq_en};
`endif
      16'h002C: w_rd_data = ID_VALUE;
      default: begin
        w_rd_err = 1'b1;
        // 0x1xx holds results, 0x2xx skip counters; bit 9 picks between them.
        if (w_rword[15:8] == 8'h01 || w_rword[15:8] == 8'h02) begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (w_rword[7:2] == 6'(k)) begin
              w_rd_err  = 1'b0;
              w_rd_data = w_rword[9] ? skip_counts[k*32 +: 32] : vector_results[k*32 +: 32];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else if (s_axi_arvalid && !r_rvalid) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_err ? 32'hDEADBEEF : w_rd_data;
      r_rresp  <= w_rd_err ? 2'b10 : 2'b00;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_arready = !r_rvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

  assign fabric_base_addr  = r_base;
  assign fabric_depth      = r_depth;
  assign fabric_stride     = r_stride;
  assign fabric_exec_hints = r_hints;
  assign fabric_lane_count = r_lcount;
  assign fabric_lane_mask  = r_mask;
  assign fabric_start      = r_start;
  assign sram_waddr        = r_sram_waddr;
  assign sram_wdata        = r_sram_wdata;
  assign sram_we_weight    = r_we_w;
  assign sram_we_input     = r_we_i;

  // Only addr[15:0] is decoded; byte-offset bits are ignored.
  assign w_unused = ^{s_axi_awaddr, s_axi_araddr, w_waddr16[1:0]};

endmodule

// File: tb/tb_axi_fabric_csr_v2.sv
// tb/tb_axi_fabric_csr_v2.sv - self-checking bench for axi_fabric_csr_v2
module tb_axi_fabric_csr_v2;
  localparam int NL = 15;

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       awaddr, wdata, araddr;
  logic [3:0]        wstrb;
  logic              awvalid, wvalid, bready, arvalid, rready;
  logic              awready, wready, bvalid, arready, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata;
  logic [31:0]       base_addr, hints;
  logic [15:0]       depth, lane_count;
  logic [7:0]        stride;
  logic [NL-1:0]     lane_mask;
  logic              start, done;
  logic [NL*32-1:0]  vector_results, skip_counts;
  logic [31:0]       cycle_count, util_count;
  logic [9:0]        sram_waddr;
  logic [23:0]       sram_wdata;
  logic              we_w, we_i;
`ifdef TFAB_IRQ_EN
  logic              irq;
`endif

  axi_fabric_csr_v2 dut (
    .s_axi_aclk(clk), .s_axi_aresetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .fabric_base_addr(base_addr), .fabric_depth(depth), .fabric_stride(stride),
    .fabric_exec_hints(hints), .fabric_lane_count(lane_count), .fabric_lane_mask(lane_mask),
    .fabric_start(start), .fabric_done(done),
    .vector_results(vector_results), .skip_counts(skip_counts),
    .cycle_count(cycle_count), .utilization_count(util_count),
`ifdef TFAB_IRQ_EN
    .irq(irq),
`endif
    .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .sram_we_weight(we_w), .sram_we_input(we_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_w_cnt = 0;
  int we_i_cnt = 0;

  always @(negedge clk) begin
    if (we_w) we_w_cnt++;
    if (we_i) we_i_cnt++;
  end

  // Reference state: config registers by word index 2..7 (0x008..0x01C).
  logic [31:0] m_reg [2:7];
  logic [31:0] m_wmask [2:7];
  logic [31:0] res_arr [NL];
  logic [31:0] skp_arr [NL];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit ad, wd, ahs, whs, got;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    ad = 0; wd = 0; got = 0; resp = 2'b11;
    for (int n = 0; n < 20 && !(ad && wd); n++) begin
      ahs = awvalid && awready;
      whs = wvalid && wready;
      tick();
      if (ahs) begin ad = 1; awvalid = 1'b0; end
      if (whs) begin wd = 1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (bvalid) begin resp = bresp; got = 1; end
      tick();
    end
    bready = 1'b0;
    chk("write_handshake", got, 1);
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit acc, got;
    araddr = a; arvalid = 1'b1; acc = 0; got = 0; d = 'x; resp = 2'b11;
    for (int n = 0; n < 20 && !acc; n++) begin
      if (arready) acc = 1;
      tick();
    end
    arvalid = 1'b0; rready = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      if (rvalid) begin d = rdata; resp = rresp; got = 1; end
      tick();
    end
    rready = 1'b0;
    chk("read_handshake", acc && got, 1);
  endtask

  function automatic logic [31:0] bytemerge(input logic [31:0] o, input logic [31:0] n,
                                            input logic [3:0] s);
    logic [31:0] v;
    v = o;
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = n[b*8 +: 8];
    return v;
  endfunction

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd, a, d, exp_v;
    logic [3:0]  s;
    int          idx, lane, wcnt;

    resetn = 1'b0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; done = 0;
    cycle_count = $urandom; util_count = $urandom;
    for (int i = 0; i < NL; i++) begin
      res_arr[i] = $urandom; skp_arr[i] = $urandom;
      vector_results[i*32 +: 32] = res_arr[i];
      skip_counts[i*32 +: 32]    = skp_arr[i];
    end
    m_reg[2] = 0; m_reg[3] = 0; m_reg[4] = 0; m_reg[5] = 0; m_reg[6] = NL; m_reg[7] = 32'h7FFF;
    m_wmask[2] = 32'hFFFFFFFF; m_wmask[3] = 32'hFFFF; m_wmask[4] = 32'hFF;
    m_wmask[5] = 32'hFFFFFFFF; m_wmask[6] = 32'hFFFF; m_wmask[7] = 32'h7FFF;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // Reset values
    chk("rst_base", base_addr, 0);
    chk("rst_depth", depth, 0);
    chk("rst_lane_count", lane_count, NL);
    chk("rst_lane_mask", lane_mask, 15'h7FFF);
    chk("rst_start", start, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 1);
    chk("rst_we", {we_w, we_i}, 0);

    // AW first, W three cycles later, bready held low five cycles
    awaddr = 32'h0C; awvalid = 1'b1; wstrb = 4'hF;
    tick();
    awvalid = 1'b0;
    chk("gota_awready", awready, 0);
    tick(); tick();
    wdata = 32'h40; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("split_bvalid", bvalid, 1);
    chk("split_bresp", bresp, 2'b00);
    chk("split_depth", depth, 16'h0040);
    m_reg[3] = 32'h40;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bvalid_held", bvalid, 1);
      chk("resp_awready_low", awready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 0);

    // Read-only and identification registers
    axi_read(32'h2C, rd, resp);
    chk("id", {resp, rd}, {2'b00, 32'h020F7E81});
    axi_read(32'h20, rd, resp);
    chk("cycle_count", rd, cycle_count);
    axi_read(32'h24, rd, resp);
    chk("util_count", rd, util_count);
    axi_read(32'h28, rd, resp);
`ifdef TFAB_IRQ_EN
    chk("irq_en_rst", {resp, rd}, {2'b00, 32'h0});
`else
    chk("irq_hole_rd", {resp, rd}, {2'b10, 32'hDEADBEEF});
`endif

    // Lane-count clamping at both ends
    axi_write(32'h18, 32'd40, 4'hF, resp);
    axi_read(32'h18, rd, resp);
    chk("lc_clamp_hi", rd, NL);
    axi_write(32'h18, 32'd0, 4'hF, resp);
    axi_read(32'h18, rd, resp);
    chk("lc_clamp_lo", rd, 1);
    m_reg[6] = 1;

    // Random config writes with random byte strobes against the model
    for (int it = 0; it < 30; it++) begin
      idx = $urandom_range(2, 7);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      axi_write(32'(idx * 4), d, s, resp);
      chk("rnd_wr_resp", resp, 2'b00);
      exp_v = bytemerge(m_reg[idx], d, s) & m_wmask[idx];
      if (idx == 6) begin
        if (exp_v == 0) exp_v = 1;
        else if (exp_v > NL) exp_v = NL;
      end
      m_reg[idx] = exp_v;
      axi_read(32'(idx * 4), rd, resp);
      chk("rnd_rd", {resp, rd}, {2'b00, exp_v});
    end
    chk("port_base", base_addr, m_reg[2]);
    chk("port_depth", depth, m_reg[3]);
    chk("port_stride", stride, m_reg[4]);
    chk("port_hints", hints, m_reg[5]);
    chk("port_lane_count", lane_count, m_reg[6]);
    chk("port_lane_mask", lane_mask, m_reg[7]);

    // Random lane reads, including the first out-of-range lane
    for (int it = 0; it < 20; it++) begin
      lane = $urandom_range(0, NL);
      a = (($urandom_range(0, 1) == 1) ? 32'h200 : 32'h100) + 32'(lane * 4);
      axi_read(a, rd, resp);
      if (lane >= NL) chk("lane_oob", {resp, rd}, {2'b10, 32'hDEADBEEF});
      else if (a[9])  chk("lane_skip", {resp, rd}, {2'b00, skp_arr[lane]});
      else            chk("lane_result", {resp, rd}, {2'b00, res_arr[lane]});
    end
    axi_read(32'h238, rd, resp);
    chk("skip_lane14", {resp, rd}, {2'b00, skp_arr[14]});
    axi_read(32'h23C, rd, resp);
    chk("skip_lane15", {resp, rd}, {2'b10, 32'hDEADBEEF});

    // Error decode on writes
    axi_write(32'h20, 32'h1234, 4'hF, resp);
    chk("wr_ro", resp, 2'b10);
    axi_write(32'h30, 32'h1234, 4'hF, resp);
    chk("wr_unmapped", resp, 2'b10);
    axi_read(32'h30, rd, resp);
    chk("rd_unmapped", {resp, rd}, {2'b10, 32'hDEADBEEF});

    // SRAM windows
    wcnt = we_w_cnt;
    axi_write(32'h1004, 32'h00ABCDEF, 4'hF, resp);
    chk("sram_w_resp", resp, 2'b00);
    chk("sram_w_pulse", we_w_cnt - wcnt, 1);
    chk("sram_w_addr", sram_waddr, 1);
    chk("sram_w_data", sram_wdata, 24'hABCDEF);
    wcnt = we_w_cnt;
    axi_write(32'h1008, 32'h00123456, 4'h3, resp);
    chk("sram_strb_err", resp, 2'b10);
    chk("sram_strb_nowe", we_w_cnt - wcnt, 0);
    for (int it = 0; it < 6; it++) begin
      idx = $urandom_range(0, 1023);
      d = $urandom;
      wcnt = we_i_cnt;
      axi_write(32'h2000 + 32'(idx * 4), d, (it == 0) ? 4'h7 : 4'hF, resp);
      chk("sram_i_resp", resp, 2'b00);
      chk("sram_i_pulse", we_i_cnt - wcnt, 1);
      chk("sram_i_addr", sram_waddr, idx);
      chk("sram_i_data", sram_wdata, d[23:0]);
    end

`ifdef TFAB_IRQ_EN
    axi_write(32'h28, 32'h1, 4'hF, resp);
    chk("irq_en_wr", resp, 2'b00);
`endif

    // Run, busy lock, done sticky
    axi_write(32'h0, 32'h1, 4'hF, resp);
    chk("ctrl_resp", resp, 2'b00);
    chk("start_set", start, 1);
    axi_read(32'h4, rd, resp);
    chk("status_busy", rd, 32'h1);
    axi_write(32'h0C, 32'hBEEF, 4'hF, resp);
    chk("busy_cfg_err", resp, 2'b10);
    chk("busy_depth_kept", depth, m_reg[3]);
    wcnt = we_w_cnt;
    axi_write(32'h1000, 32'h1, 4'hF, resp);
    chk("busy_sram_err", resp, 2'b10);
    chk("busy_sram_nowe", we_w_cnt - wcnt, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("start_cleared", start, 0);
`ifdef TFAB_IRQ_EN
    chk("irq_lag", irq, 0);
    tick();
    chk("irq_set", irq, 1);
`endif
    axi_read(32'h4, rd, resp);
    chk("status_done", rd, 32'h2);
    axi_write(32'h4, 32'h2, 4'hF, resp);
    axi_read(32'h4, rd, resp);
    chk("status_w1c", rd, 32'h0);
`ifdef TFAB_IRQ_EN
    chk("irq_clr", irq, 0);
`endif

    // Start write coinciding with fabric_done: the write wins
    awaddr = 32'h0; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; done = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; done = 1'b0;
    chk("race_start", start, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(32'h4, rd, resp);
    chk("race_status", rd, 32'h1);
    done = 1'b1;
    tick();
    done = 1'b0;
    axi_write(32'h4, 32'h2, 4'hF, resp);
    chk("race_idle", start, 0);

    // Asynchronous reset while a write response is pending
    axi_write(32'h1C, 32'h5, 4'hF, resp);
    axi_write(32'h18, 32'h3, 4'hF, resp);
    awaddr = 32'h0C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("pre_rst_bvalid", bvalid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_bvalid", bvalid, 0);
    chk("async_lane_mask", lane_mask, 15'h7FFF);
    chk("async_lane_count", lane_count, NL);
    chk("async_depth", depth, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("post_rst_awready", awready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
